// File: rtl/pwm_pkg.sv
// Shared constants and config-word decode for the PWM dither generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

  localparam int CCW      = 24;  // config word width
  localparam int DUTY_W   = 8;   // duty / period counter width
  localparam int SEQ_W    = 16;  // dither sequence length in periods
  localparam int IDX_W    = 4;   // period index width, 2**IDX_W == SEQ_W

  localparam int DUTY_MSB = 23;
  localparam int DUTY_LSB = 16;
  localparam int SEQ_MSB  = 15;

  // Decoded fields of one config word.
  typedef struct packed {
    logic [DUTY_W-1:0] duty;
    logic [SEQ_W-1:0]  seq;
  } cfg_t;

  function automatic cfg_t unpack_cfg(input logic [CCW-1:0] word);
    cfg_t c;
    c.duty = word[DUTY_MSB:DUTY_LSB];
    c.seq  = word[SEQ_MSB:0];
    return c;
  endfunction

endpackage

// File: rtl/pwm_frame_cnt.sv
// Period counter (cnt) and period index (idx) with period/frame strobes.
// Latency: strobes are combinational decodes of the current counter state.
// Backpressure: none; free-running every clock.
//
// Ports:
//   clk_i, rstn_i  clock, async active-low reset
//   cnt            position within the 2**DUTY_W-cycle PWM period
//   idx            period number within the dither frame
//   period_end     cnt at its last value
//   frame_end      last cycle of the last period of the frame
//   frame_start    first cycle of the first period of the frame
module pwm_frame_cnt
  import pwm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rstn_i,
  output logic [DUTY_W-1:0] cnt,
  output logic [IDX_W-1:0]  idx,
  output logic              period_end,
  output logic              frame_end,
  output logic              frame_start
);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + DUTY_W'(1);
      if (period_end) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  assign period_end  = (cnt == '1);
  assign frame_end   = period_end && (idx == '1);
  assign frame_start = (cnt == '0) && (idx == '0);

endmodule

// File: rtl/pwm_dither_gen.sv
// 8-bit PWM at clk_i/256, duty refined by a 16-period dither sequence (12-bit average).
// Latency: pwm_o is registered, one cycle behind cnt; cfg_i takes effect after the next frame boundary.
// Backpressure: none; cfg_i is sampled only at frame (or period) boundaries, other changes are ignored.
//
// Ports:
//   clk_i      PWM clock
//   rstn_i     async active-low reset
//   cfg_i      [23:16] duty, [15:0] dither sequence (bit n applies to period n)
//   pwm_o      registered PWM output to the RC filter
//   sync_o     pulse on the first output cycle of a frame
//   cfg_upd_o  pulse on the cycle cfg_i is copied into the shadow registers
//
// Build option: PWM_DITHER_EN. When undefined there is no dither, the frame
// collapses to a single period and duty is re-sampled every period.
module pwm_dither_gen
  import pwm_pkg::*;
(
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic [CCW-1:0] cfg_i,
  output logic           pwm_o,
  output logic           sync_o,
  output logic           cfg_upd_o
);

  cfg_t              cfg_in;
  logic [DUTY_W-1:0] cnt;
  logic [IDX_W-1:0]  idx;
  logic              period_end;
  logic              frame_end;
  logic              frame_start;
  logic              latch_stb;
  logic              start_stb;
  logic              dbit;
  logic [DUTY_W-1:0] duty_r;
  logic [DUTY_W:0]   thr;

  assign cfg_in = unpack_cfg(cfg_i);

  pwm_frame_cnt u_frame_cnt (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .cnt         (cnt),
    .idx         (idx),
    .period_end  (period_end),
    .frame_end   (frame_end),
    .frame_start (frame_start)
  );

`ifdef PWM_DITHER_EN
  logic [SEQ_W-1:0] seq_r;
  logic             unused_period;

  assign latch_stb     = frame_end;
  assign start_stb     = frame_start;
  assign dbit          = seq_r[idx];
  assign unused_period = period_end;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      seq_r <= '0;
    end else if (latch_stb) begin
      seq_r <= cfg_in.seq;
    end
  end
`else
  logic unused_nodither;

  assign latch_stb       = period_end;
  assign start_stb       = (cnt == '0);
  assign dbit            = 1'b0;
  assign unused_nodither = ^{idx, frame_end, frame_start, cfg_in.seq};
`endif

  // 9-bit threshold so duty 255 plus a dither bit reaches 256 (always high).
  assign thr = {1'b0, duty_r} + {{DUTY_W{1'b0}}, dbit};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      duty_r    <= '0;
      pwm_o     <= 1'b0;
      sync_o    <= 1'b0;
      cfg_upd_o <= 1'b0;
    end else begin
      if (latch_stb) begin
        duty_r <= cfg_in.duty;
      end
      pwm_o     <= ({1'b0, cnt} < thr);
      sync_o    <= start_stb;
      cfg_upd_o <= latch_stb;
    end
  end

endmodule

// File: tb/tb_pwm_dither_gen.sv
// Directed bench for pwm_dither_gen; expected counts are hand-computed per build option.
// Outputs are sampled on the falling edge, inputs change on the falling edge.
// Each measurement window starts on the cycle where sync_o is high.
module tb_pwm_dither_gen;

`ifdef PWM_DITHER_EN
  localparam int FRAME     = 4096;
  localparam int NPER      = 16;
  localparam int EXP_FULL  = 4096;  // 16*255 + 16
  localparam int EXP_MIN   = 1;     // seq bit 0 only
  localparam int EVEN_5555 = 65;
  localparam int EXP_5555  = 1032;  // 16*64 + 8
  localparam int EXP_A     = 256;   // 16*16
  localparam int EXP_B     = 512;   // 16*32
`else
  localparam int FRAME     = 256;
  localparam int NPER      = 1;
  localparam int EXP_FULL  = 255;
  localparam int EXP_MIN   = 0;
  localparam int EVEN_5555 = 64;
  localparam int EXP_5555  = 64;
  localparam int EXP_A     = 16;
  localparam int EXP_B     = 32;
`endif

  localparam logic [23:0] CFG_A = 24'h10_0000;
  localparam logic [23:0] CFG_B = 24'h20_0000;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [23:0] cfg_i;
  logic        pwm_o;
  logic        sync_o;
  logic        cfg_upd_o;

  always #5 clk_i = ~clk_i;

  pwm_dither_gen dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .cfg_i     (cfg_i),
    .pwm_o     (pwm_o),
    .sync_o    (sync_o),
    .cfg_upd_o (cfg_upd_o)
  );

  int checks   = 0;
  int failures = 0;
  int per_hi[32];
  int tot_hi, sync_cnt, sync_bad, upd_cnt, upd_bad, shape_bad;

  // Samples n cycles from the current falling edge and leaves the bench on
  // the falling edge right after the window. tog_phase>=0 swaps cfg_i
  // between a and b whenever i%100 == tog_phase.
  task automatic measure(input int n, input int tog_phase,
                         input logic [23:0] a, input logic [23:0] b);
    logic prev;
    prev = 1'b1;
    tot_hi = 0; sync_cnt = 0; sync_bad = 0; upd_cnt = 0; upd_bad = 0; shape_bad = 0;
    for (int p = 0; p < 32; p++) per_hi[p] = 0;
    for (int i = 0; i < n; i++) begin
      if (i % 256 == 0) prev = 1'b1;
      if (pwm_o === 1'b1) begin
        per_hi[i/256]++;
        tot_hi++;
        if (!prev) shape_bad++;
      end
      prev = (pwm_o === 1'b1);
      if (sync_o === 1'b1) sync_cnt++;
      if (sync_o !== (i % FRAME == 0)) sync_bad++;
      if (cfg_upd_o === 1'b1) upd_cnt++;
      if (cfg_upd_o !== (i % FRAME == FRAME - 1)) upd_bad++;
      if (tog_phase >= 0 && i % 100 == tog_phase) cfg_i = (cfg_i == a) ? b : a;
      @(negedge clk_i);
    end
  endtask

  // Advances at least two cycles, so a config written just before the call
  // is in place at the boundary preceding the frame found here.
  task automatic wait_sync(input string name);
    bit found;
    found = 1'b0;
    repeat (2) @(negedge clk_i);
    for (int k = 0; k < FRAME + 4 && !found; k++) begin
      if (sync_o === 1'b1) found = 1'b1;
      else @(negedge clk_i);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s_sync_timeout got=0 exp=1", name);
    end
  endtask

  task automatic test_reset();
    rstn_i = 1'b1;
    cfg_i  = 24'h80_0000;
    #1 rstn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++; if (pwm_o !== 1'b0) begin failures++; $display("FAIL reset_pwm got=%b exp=0", pwm_o); end
    checks++; if (sync_o !== 1'b0) begin failures++; $display("FAIL reset_sync got=%b exp=0", sync_o); end
    checks++; if (cfg_upd_o !== 1'b0) begin failures++; $display("FAIL reset_upd got=%b exp=0", cfg_upd_o); end
    rstn_i = 1'b1;
    @(negedge clk_i);
    checks++; if (sync_o !== 1'b1) begin failures++; $display("FAIL sync_after_release got=%b exp=1", sync_o); end
    measure(FRAME, -1, 24'h0, 24'h0);
    checks++; if (tot_hi != 0) begin failures++; $display("FAIL first_frame_low got=%0d exp=0", tot_hi); end
  endtask

  task automatic test_half_duty();
    measure(2 * FRAME, -1, 24'h0, 24'h0);
    checks++; if (tot_hi != 2 * 128 * NPER) begin failures++; $display("FAIL half_total got=%0d exp=%0d", tot_hi, 2 * 128 * NPER); end
    checks++; if (per_hi[0] != 128) begin failures++; $display("FAIL half_period0 got=%0d exp=128", per_hi[0]); end
    checks++; if (shape_bad != 0) begin failures++; $display("FAIL half_contiguous got=%0d exp=0", shape_bad); end
    checks++; if (sync_cnt != 2) begin failures++; $display("FAIL half_sync_count got=%0d exp=2", sync_cnt); end
    checks++; if (sync_bad != 0) begin failures++; $display("FAIL half_sync_position got=%0d exp=0", sync_bad); end
    checks++; if (upd_cnt != 2) begin failures++; $display("FAIL half_upd_count got=%0d exp=2", upd_cnt); end
    checks++; if (upd_bad != 0) begin failures++; $display("FAIL half_upd_position got=%0d exp=0", upd_bad); end
  endtask

  task automatic test_full_then_zero();
    cfg_i = 24'hFF_FFFF;
    wait_sync("full");
    measure(FRAME, -1, 24'h0, 24'h0);
    checks++; if (tot_hi != EXP_FULL) begin failures++; $display("FAIL full_total got=%0d exp=%0d", tot_hi, EXP_FULL); end
    checks++; if (upd_bad != 0) begin failures++; $display("FAIL full_upd_position got=%0d exp=0", upd_bad); end
    cfg_i = 24'h00_0000;
    wait_sync("zero");
    measure(FRAME, -1, 24'h0, 24'h0);
    checks++; if (tot_hi != 0) begin failures++; $display("FAIL zero_total got=%0d exp=0", tot_hi); end
  endtask

  task automatic test_min_dither();
    cfg_i = 24'h00_0001;
    wait_sync("min");
    measure(FRAME, -1, 24'h0, 24'h0);
    checks++; if (per_hi[0] != EXP_MIN) begin failures++; $display("FAIL min_period0 got=%0d exp=%0d", per_hi[0], EXP_MIN); end
    checks++; if (tot_hi != EXP_MIN) begin failures++; $display("FAIL min_total got=%0d exp=%0d", tot_hi, EXP_MIN); end
    checks++; if (shape_bad != 0) begin failures++; $display("FAIL min_at_cnt0 got=%0d exp=0", shape_bad); end
  endtask

  task automatic test_pattern_5555();
    int bad;
    cfg_i = 24'h40_5555;
    wait_sync("p5555");
    measure(FRAME, -1, 24'h0, 24'h0);
    bad = 0;
    for (int p = 0; p < NPER; p++)
      if (per_hi[p] != ((p % 2 == 0) ? EVEN_5555 : 64)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL p5555_periods got=%0d_wrong exp=0_wrong", bad); end
    checks++; if (tot_hi != EXP_5555) begin failures++; $display("FAIL p5555_total got=%0d exp=%0d", tot_hi, EXP_5555); end
    checks++; if (upd_cnt != 1) begin failures++; $display("FAIL p5555_upd_count got=%0d exp=1", upd_cnt); end
  endtask

  task automatic test_toggle();
    cfg_i = CFG_A;
    wait_sync("toggle");
    // Frame uses A; an even number of swaps leaves A at the boundary.
    measure(FRAME, 99, CFG_A, CFG_B);
    checks++; if (tot_hi != EXP_A) begin failures++; $display("FAIL toggle_f1 got=%0d exp=%0d", tot_hi, EXP_A); end
    // Still A despite B being present for half the previous frame; odd swaps leave B.
    measure(FRAME, 49, CFG_A, CFG_B);
    checks++; if (tot_hi != EXP_A) begin failures++; $display("FAIL toggle_f2 got=%0d exp=%0d", tot_hi, EXP_A); end
    measure(FRAME, -1, CFG_A, CFG_B);
    checks++; if (tot_hi != EXP_B) begin failures++; $display("FAIL toggle_f3 got=%0d exp=%0d", tot_hi, EXP_B); end
  endtask

  task automatic test_reset_mid();
    cfg_i = 24'h80_0000;
    wait_sync("rmid");
    repeat (100) @(negedge clk_i);
    checks++; if (pwm_o !== 1'b1) begin failures++; $display("FAIL rmid_pwm_before got=%b exp=1", pwm_o); end
    #1 rstn_i = 1'b0;
    #1;
    checks++; if (pwm_o !== 1'b0) begin failures++; $display("FAIL rmid_pwm_async got=%b exp=0", pwm_o); end
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    checks++; if (sync_o !== 1'b1) begin failures++; $display("FAIL rmid_sync_after got=%b exp=1", sync_o); end
    measure(FRAME, -1, 24'h0, 24'h0);
    checks++; if (tot_hi != 0) begin failures++; $display("FAIL rmid_first_frame got=%0d exp=0", tot_hi); end
    measure(FRAME, -1, 24'h0, 24'h0);
    checks++; if (tot_hi != 128 * NPER) begin failures++; $display("FAIL rmid_second_frame got=%0d exp=%0d", tot_hi, 128 * NPER); end
  endtask

  initial begin
    test_reset();
    test_half_duty();
    test_full_then_zero();
    test_min_dither();
    test_pattern_5555();
    test_toggle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
